// File: rtl/stage_execute_muldiv_pkg.sv
// Shared alu_op codes and latency defaults for the execute stage.
// Imported by the mul/div unit and its bench.
package stage_execute_muldiv_pkg;

  localparam int ALU_OP_LEN = 6;

  localparam logic [ALU_OP_LEN-1:0] ALU_OP_NOP   = 6'h00;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_MFHI  = 6'h10;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_MTHI  = 6'h11;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_MFLO  = 6'h12;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_MTLO  = 6'h13;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_MULT  = 6'h18;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_MULTU = 6'h19;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_DIV   = 6'h1a;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_DIVU  = 6'h1b;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  function automatic logic is_hilo_op(
    input logic [ALU_OP_LEN-1:0] op
  );
    return op[ALU_OP_LEN-1:4] == 2'b01;
  endfunction

endpackage

// File: rtl/stage_execute_muldiv.sv
// Execute-stage multiply/divide unit owning HI/LO.
// Results land in HI/LO after a fixed busy latency.
module stage_execute_muldiv
  import stage_execute_muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  valid,
  input  logic                  cancel,
  input  logic [ALU_OP_LEN-1:0] op,
  input  logic [31:0]           src0,
  input  logic [31:0]           src1,
  output logic                  busy,
  output logic                  stall_req,
  output logic [31:0]           hi,
  output logic [31:0]           lo,
  output logic [31:0]           result
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;

  logic accept;
  logic is_mul;
  logic is_div;
  logic sgn;
  logic do_mthi;
  logic do_mtlo;
  logic start;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] n_hi;
  logic [31:0] n_lo;
  logic [CW-1:0] load;

  assign busy   = cnt != '0;
  assign accept = valid & ~cancel & ~busy;

  // Decode the op into start / move-to controls.
  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    sgn     = 1'b0;
    do_mthi = 1'b0;
    do_mtlo = 1'b0;
    unique case (op)
      ALU_OP_MULT:  begin is_mul = 1'b1; sgn = 1'b1; end
      ALU_OP_MULTU: is_mul = 1'b1;
      ALU_OP_DIV:   begin is_div = 1'b1; sgn = 1'b1; end
      ALU_OP_DIVU:  is_div = 1'b1;
      ALU_OP_MTHI:  do_mthi = accept;
      ALU_OP_MTLO:  do_mtlo = accept;
      default:      ;
    endcase
  end

  assign start     = accept & (is_mul | is_div);
  assign stall_req = busy | start;

  assign prod_s = $signed({{32{src0[31]}}, src0})
                * $signed({{32{src1[31]}}, src1});
  assign prod_u = {32'd0, src0} * {32'd0, src1};

  // Divide magnitudes, then restore signs; this also
  // yields 0x80000000 / -1 = 0x80000000 rem 0.
  assign dvd = (sgn & src0[31]) ? -src0 : src0;
  assign dvs = (sgn & src1[31]) ? -src1 : src1;
  assign uq  = (dvs != '0) ? dvd / dvs : '0;
  assign ur  = (dvs != '0) ? dvd % dvs : '0;

  // Pick the value that HI/LO will take at completion.
  always_comb begin
    n_hi = hi;
    n_lo = lo;
    load = CW'(DIV_CYCLES);
    if (is_mul) begin
      load = CW'(MULT_CYCLES);
      {n_hi, n_lo} = sgn ? prod_s : prod_u;
    end else if (src1 != '0) begin
      n_lo = (sgn & (src0[31] ^ src1[31])) ? -uq : uq;
      n_hi = (sgn & src0[31]) ? -ur : ur;
    end
  end

  // Busy counter, pending result and HI/LO commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (start) begin
        cnt     <= load;
        pend_hi <= n_hi;
        pend_lo <= n_lo;
      end else if (busy) begin
        cnt <= cnt - CW'(1);
      end
      if (cnt == CW'(1)) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end else begin
        if (do_mthi) hi <= src0;
        if (do_mtlo) lo <= src0;
      end
    end
  end

  // Move-from result straight off the architectural regs.
  always_comb begin
    result = '0;
    if (op == ALU_OP_MFHI)      result = hi;
    else if (op == ALU_OP_MFLO) result = lo;
  end

endmodule
